// File: rtl/tl_pkg.sv
// tl_pkg: shared phase encoding, lamp codes and phase sequencing for the traffic-light controller
package tl_pkg;
    typedef enum logic [2:0] {NS_G, NS_Y, RED1, EW_G, EW_Y, RED2, NIGHT} phase_e;
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;
    // NIGHT always leaves through RED2 so traffic restarts after all-red clearance
    function automatic phase_e next_phase(input phase_e p);
        case (p)
            NS_G:    return NS_Y;
            NS_Y:    return RED1;
            RED1:    return EW_G;
            EW_G:    return EW_Y;
            EW_Y:    return RED2;
            default: return NS_G;
        endcase
    endfunction
endpackage

// File: rtl/tl_bin2bcd.sv
// tl_bin2bcd: combinational binary (0..99) to two BCD digits
//   bin  : binary value
//   tens : bin / 10
//   ones : bin % 10
module tl_bin2bcd #(
    parameter int W = 7
) (
    input  logic [W-1:0] bin,
    output logic [3:0]   tens,
    output logic [3:0]   ones
);
    assign tens = 4'(bin / W'(10));
    assign ones = 4'(bin % W'(10));
endmodule

// File: rtl/tl_phase_ctrl.sv
// tl_phase_ctrl: two-way intersection phase sequencer with manual step and night flash
//   clk, rst       : clock, synchronous active-high reset
//   sec_tick       : 1 pulse per second
//   manual_en      : freeze countdown, step with adv_btn
//   adv_btn        : advance one phase in manual mode
//   night_en       : flashing-yellow mode (highest priority)
//   ns_light       : NS lamps {R,Y,G}
//   ew_light       : EW lamps {R,Y,G}
//   remain         : seconds left in current phase
//   remain_tens/_ones : BCD digits of remain
//   phase_chg      : pulse on every phase change
module tl_phase_ctrl
    import tl_pkg::*;
#(
    parameter int T_GREEN  = 25,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec_tick,
    input  logic             manual_en,
    input  logic             adv_btn,
    input  logic             night_en,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [CNT_W-1:0] remain,
    output logic [3:0]       remain_tens,
    output logic [3:0]       remain_ones,
    output logic             phase_chg
);
    phase_e           state, state_n;
    logic [CNT_W-1:0] remain_n;
    logic             flash, flash_n;

    function automatic logic [CNT_W-1:0] dur(input phase_e p);
        return (p == NS_G || p == EW_G) ? CNT_W'(T_GREEN) :
               (p == NS_Y || p == EW_Y) ? CNT_W'(T_YELLOW) : CNT_W'(T_ALLRED);
    endfunction

    // {ns, ew}; lamps are registered from the next state so they change with it
    function automatic logic [5:0] lamps(input phase_e p, input logic f);
        case (p)
            NS_G:    return {LAMP_G, LAMP_R};
            NS_Y:    return {LAMP_Y, LAMP_R};
            EW_G:    return {LAMP_R, LAMP_G};
            EW_Y:    return {LAMP_R, LAMP_Y};
            NIGHT:   return f ? {LAMP_Y, LAMP_Y} : {LAMP_OFF, LAMP_OFF};
            default: return {LAMP_R, LAMP_R};
        endcase
    endfunction

    // reload at remain==1 wins over decrement, so remain never reaches 0 outside NIGHT
    always_comb begin
        state_n  = state;
        remain_n = remain;
        flash_n  = flash;
        if (night_en) begin
            if (state != NIGHT) begin
                state_n  = NIGHT;
                flash_n  = 1'b1;
                remain_n = '0;
            end else if (sec_tick) begin
                flash_n = ~flash;
            end
        end else if (state == NIGHT) begin
            state_n  = RED2;
            remain_n = dur(RED2);
            flash_n  = 1'b1;
        end else if (manual_en ? adv_btn : (sec_tick && remain == CNT_W'(1))) begin
            state_n  = next_phase(state);
            remain_n = dur(state_n);
        end else if (!manual_en && sec_tick) begin
            remain_n = remain - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= RED2;
            remain               <= CNT_W'(T_ALLRED);
            flash                <= 1'b1;
            phase_chg            <= 1'b0;
            {ns_light, ew_light} <= {LAMP_R, LAMP_R};
        end else begin
            state                <= state_n;
            remain               <= remain_n;
            flash                <= flash_n;
            phase_chg            <= state_n != state;
            {ns_light, ew_light} <= lamps(state_n, flash_n);
        end
    end

    tl_bin2bcd #(.W(CNT_W)) u_bcd (
        .bin  (remain),
        .tens (remain_tens),
        .ones (remain_ones)
    );
endmodule

// File: tb/tb_tl_phase_ctrl.sv
// tb_tl_phase_ctrl: directed scoreboard bench for tl_phase_ctrl
module tb_tl_phase_ctrl;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, sec_tick = 1'b0, manual_en = 1'b0, adv_btn = 1'b0, night_en = 1'b0;
    logic rst_b = 1'b1, tick_b = 1'b0;
    logic [2:0] ns_a, ew_a, ns_b, ew_b;
    logic [6:0] rem_a, rem_b;
    logic [3:0] tens_a, ones_a, tens_b, ones_b;
    logic chg_a, chg_b;

    tl_phase_ctrl #(.T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1), .CNT_W(7)) dut_a (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .manual_en(manual_en), .adv_btn(adv_btn),
        .night_en(night_en), .ns_light(ns_a), .ew_light(ew_a), .remain(rem_a),
        .remain_tens(tens_a), .remain_ones(ones_a), .phase_chg(chg_a));

    tl_phase_ctrl #(.T_GREEN(99), .T_YELLOW(2), .T_ALLRED(1), .CNT_W(7)) dut_b (
        .clk(clk), .rst(rst_b), .sec_tick(tick_b), .manual_en(1'b0), .adv_btn(1'b0),
        .night_en(1'b0), .ns_light(ns_b), .ew_light(ew_b), .remain(rem_b),
        .remain_tens(tens_b), .remain_ones(ones_b), .phase_chg(chg_b));

    typedef struct {
        string      tag;
        logic [2:0] ns, ew;
        logic [6:0] rem;
        logic [3:0] tens, ones;
        logic       chg;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    logic [2:0] t_ns [16] = '{G, G, G, G, Y, Y, R, R, R, R, R, R, R, R, R, G};
    logic [2:0] t_ew [16] = '{R, R, R, R, R, R, R, G, G, G, G, G, Y, Y, R, R};
    int         t_rem[16] = '{4, 3, 2, 1, 2, 1, 1, 5, 4, 3, 2, 1, 2, 1, 1, 5};
    logic       t_chg[16] = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1};

    task automatic chk(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s %s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input bit b);
        repeat (3) cyc();
        if (b) tick_b = 1'b1; else sec_tick = 1'b1;
        cyc();
        tick_b   = 1'b0;
        sec_tick = 1'b0;
    endtask

    task automatic push(input string tag, input logic [2:0] ns, input logic [2:0] ew, input int rem, input logic chg);
        exp_t e;
        e.tag  = tag;
        e.ns   = ns;
        e.ew   = ew;
        e.rem  = 7'(rem);
        e.tens = 4'(rem / 10);
        e.ones = 4'(rem % 10);
        e.chg  = chg;
        q.push_back(e);
    endtask

    task automatic cmp(input bit b);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = q.pop_front();
        chk(e.tag, "ns",   b ? ns_b   : ns_a,   e.ns);
        chk(e.tag, "ew",   b ? ew_b   : ew_a,   e.ew);
        chk(e.tag, "rem",  b ? rem_b  : rem_a,  e.rem);
        chk(e.tag, "tens", b ? tens_b : tens_a, e.tens);
        chk(e.tag, "ones", b ? ones_b : ones_a, e.ones);
        chk(e.tag, "chg",  b ? chg_b  : chg_a,  e.chg);
    endtask

    // kind: 0 = one idle cycle, 1 = one second tick, 2 = adv_btn pulse
    task automatic act(input int kind, input bit b, input string tag,
                       input logic [2:0] ns, input logic [2:0] ew, input int rem, input logic chg);
        push(tag, ns, ew, rem, chg);
        if (kind == 1) tick(b);
        else if (kind == 2) begin
            adv_btn = 1'b1;
            cyc();
            adv_btn = 1'b0;
        end else cyc();
        cmp(b);
    endtask

    // lamps one-hot or off, and never both non-red unless both show the same night code
    always @(negedge clk) if (!rst) begin
        checks++;
        assert ($onehot0(ns_a) && $onehot0(ew_a) &&
                (ns_a == R || ew_a == R || (ns_a == ew_a && (ns_a == Y || ns_a == O)))) else begin
            errors++;
            $error("FAIL lamp_safety observed=%b/%b expected=one-hot,one red", ns_a, ew_a);
        end
    end

    initial begin
        repeat (2) cyc();
        rst = 1'b0;
        push("reset", R, R, 1, 0);
        cmp(0);
        act(1, 0, "t1_enter_nsg", G, R, 5, 1);
        act(0, 0, "t1_chg_low", G, R, 5, 0);
        for (int i = 0; i < 16; i++) act(1, 0, $sformatf("t1_cycle%0d", i), t_ns[i], t_ew[i], t_rem[i], t_chg[i]);
        act(1, 0, "t2_rem4", G, R, 4, 0);
        act(1, 0, "t2_rem3", G, R, 3, 0);
        manual_en = 1'b1;
        act(0, 0, "t2_manual_on", G, R, 3, 0);
        for (int i = 0; i < 10; i++) act(1, 0, $sformatf("t2_frozen%0d", i), G, R, 3, 0);
        act(2, 0, "t2_adv_nsy", Y, R, 2, 1);
        act(0, 0, "t2_adv_chg_low", Y, R, 2, 0);
        manual_en = 1'b0;
        act(1, 0, "t2_resume", Y, R, 1, 0);
        act(1, 0, "t2_red1", R, R, 1, 1);
        manual_en = 1'b1;
        act(2, 0, "t3_ewg", R, G, 5, 1);
        act(2, 0, "t3_ewy", R, Y, 2, 1);
        act(2, 0, "t3_red2", R, R, 1, 1);
        act(2, 0, "t3_nsg", G, R, 5, 1);
        push("t3_adv_tick", Y, R, 2, 1);
        adv_btn  = 1'b1;
        sec_tick = 1'b1;
        cyc();
        adv_btn  = 1'b0;
        sec_tick = 1'b0;
        cmp(0);
        act(0, 0, "t3_hold", Y, R, 2, 0);
        act(2, 0, "t3_red1", R, R, 1, 1);
        act(2, 0, "t3_ewg2", R, G, 5, 1);
        manual_en = 1'b0;
        act(0, 0, "t4_pre_ewg", R, G, 5, 0);
        night_en = 1'b1;
        act(0, 0, "t4_night", Y, Y, 0, 1);
        act(0, 0, "t4_night_hold", Y, Y, 0, 0);
        act(1, 0, "t4_flash_off", O, O, 0, 0);
        act(1, 0, "t4_flash_on", Y, Y, 0, 0);
        act(2, 0, "t4_adv_ignored", Y, Y, 0, 0);
        act(1, 0, "t4_flash_off2", O, O, 0, 0);
        night_en = 1'b0;
        act(0, 0, "t4_exit_red2", R, R, 1, 1);
        act(1, 0, "t4_nsg", G, R, 5, 1);
        manual_en = 1'b1;
        act(2, 0, "t5_nsy", Y, R, 2, 1);
        act(2, 0, "t5_red1", R, R, 1, 1);
        act(2, 0, "t5_ewg", R, G, 5, 1);
        act(2, 0, "t5_ewy", R, Y, 2, 1);
        rst = 1'b1;
        act(0, 0, "t5_reset", R, R, 1, 0);
        rst = 1'b0;
        manual_en = 1'b0;
        act(0, 0, "t5_after_reset", R, R, 1, 0);
        rst_b = 1'b0;
        push("t6_reset", R, R, 1, 0);
        cmp(1);
        act(1, 1, "t6_enter99", G, R, 99, 1);
        repeat (88) tick(1);
        act(1, 1, "t6_rem10", G, R, 10, 0);
        act(1, 1, "t6_rem9", G, R, 9, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
